// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM for the 8-bit MIPS core. Decodes opcode/funct,
// sequences each instruction over 3-5 cycles, drives the datapath strobes
// and guards every memory access with a bounded mem_ready wait.
module mips_mc_ctrl #(
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned MEM_TIMEOUT     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       z,
  input  logic       mem_ready,
  output logic [2:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,  S_DECODE    = 4'd1,  S_MEM_ADDR = 4'd2,
    S_MEM_READ  = 4'd3,  S_MEM_WB    = 4'd4,  S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,  S_R_WB      = 4'd7,  S_BRANCH   = 4'd8,
    S_JUMP      = 4'd9,  S_ADDI_EXEC = 4'd10, S_ADDI_WB  = 4'd11,
    S_HALT      = 4'd12
  } state_e;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011, ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  // Wait counter value that, once reached without mem_ready, is a bus error.
  localparam logic [4:0] WAIT_LIMIT = 5'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic       is_sw_q, is_sw_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;

  state_e     dec_next;
  logic [2:0] dec_sel;
  logic       dec_illegal;
  logic       wait_expired;

  // Instruction decode: next state and R-type ALU function from the IR fields.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    dec_next    = S_FETCH;
    dec_sel     = ALU_ADD;
    dec_illegal = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec_next = S_R_EXEC;
        case (funct)
          6'b100100: dec_sel = ALU_AND;
          6'b100101: dec_sel = ALU_OR;
          6'b100000: dec_sel = ALU_ADD;
          6'b100111: dec_sel = ALU_NOR;
          6'b100010: dec_sel = ALU_SUB;
          6'b101010: dec_sel = ALU_SLT;
          default:   dec_illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW: dec_next = S_MEM_ADDR;
      OP_BEQ:       dec_next = S_BRANCH;
      OP_ADDI:      dec_next = S_ADDI_EXEC;
      OP_J:         dec_next = S_JUMP;
      default:      dec_illegal = 1'b1;
    endcase
    if (dec_illegal) dec_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
  end

  // Expiry happens on the cycle the counter would reach the limit; mem_ready wins.
  assign wait_expired = !mem_ready && (({1'b0, wait_cnt_q} + 5'd1) == WAIT_LIMIT);

  // Next-state logic; the wait counter idles at zero so every wait state entry starts clean.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    alu_sel_d  = alu_sel_q;
    is_sw_d    = is_sw_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_MEM_READ: state_d = S_MEM_WB;
            default:    state_d = S_FETCH;
          endcase
        end else if (wait_expired) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        state_d   = dec_next;
        alu_sel_d = dec_sel;
        is_sw_d   = (opcode == OP_SW);
        if (dec_illegal && HALT_ON_ILLEGAL) illegal_d = 1'b1;
      end
      S_MEM_ADDR:  state_d = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // State and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      alu_sel_q  <= ALU_ADD;
      is_sw_q    <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      alu_sel_q  <= alu_sel_d;
      is_sw_q    <= is_sw_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Moore datapath controls; pc_write/ir_write follow mem_ready in FETCH and z in BRANCH.
  always_comb begin
    alu_sel    = '0;
    alu_src_a  = 1'b0;
    alu_src_b  = '0;
    pc_src     = '0;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_sel   = ALU_ADD;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_sel   = ALU_ADD;
          illegal   = dec_illegal;
        end
        S_MEM_ADDR, S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_sel   = ALU_ADD;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_sel   = alu_sel_q;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_ADDI_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_sel   = ALU_SUB;
          pc_src    = 2'b01;
          pc_write  = z;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
      illegal = illegal | illegal_q;
      bus_err = bus_err_q;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: a directed vector table, hand-built
// corner sequences, and randomized instruction streams checked cycle by cycle
// against an instruction-level trace model.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       z, mem_ready;
  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, illegal, bus_err;
  logic [3:0] state;

  mips_mc_ctrl #(.HALT_ON_ILLEGAL(1'b1), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .z(z),
    .mem_ready(mem_ready), .alu_sel(alu_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] alu_sel;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, illegal, bus_err;
    logic [3:0] state;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdy;
    logic       zz;
    ctrl_t      exp;
  } vec_t;

  ctrl_t act;
  assign act = {alu_sel, alu_src_a, alu_src_b, pc_src, pc_write, iord, mem_read,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal,
                bus_err, state};

  int         vectors = 0;
  int         miscompares = 0;
  bit         ill_s, berr_s;
  logic [5:0] cur_op, cur_fn;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100000: return 3'b010;
      6'b100111: return 3'b011;
      6'b100010: return 3'b110;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic bit legal_funct(input logic [5:0] fn);
    return fn inside {6'b100100, 6'b100101, 6'b100000, 6'b100111, 6'b100010, 6'b101010};
  endfunction

  function automatic bit is_illegal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_R) return !legal_funct(fn);
    return !(op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
  endfunction

  // Expected control word for a given state number and the inputs of that cycle.
  function automatic ctrl_t exp_out(input int st, input bit rdy, input bit zz);
    ctrl_t e = '0;
    case (st)
      0:  begin e.alu_sel = 3'b010; e.src_b = 2'b01; e.mem_read = 1'b1;
                e.pc_write = rdy; e.ir_write = rdy; end
      1:  begin e.alu_sel = 3'b010; e.src_b = 2'b11; e.illegal = is_illegal(cur_op, cur_fn); end
      2, 10: begin e.alu_sel = 3'b010; e.src_a = 1'b1; e.src_b = 2'b10; end
      3:  begin e.mem_read = 1'b1; e.iord = 1'b1; end
      4:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      5:  begin e.mem_write = 1'b1; e.iord = 1'b1; end
      6:  begin e.src_a = 1'b1; e.alu_sel = alu_of(cur_fn); end
      7:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      8:  begin e.src_a = 1'b1; e.alu_sel = 3'b110; e.pc_src = 2'b01; e.pc_write = zz; end
      9:  begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      11: e.reg_write = 1'b1;
      default: ;
    endcase
    e.illegal = e.illegal | ill_s;
    e.bus_err = berr_s;
    e.state   = 4'(st);
    return e;
  endfunction

  task automatic check(input string name, input ctrl_t a, input ctrl_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h (state %0d) required %h (state %0d)", name, a, a.state, e, e.state);
    end
  endtask

  // Drive one cycle of inputs, compare mid-cycle, then advance past the next edge.
  task automatic apply_vec(input vec_t v, input string name);
    opcode = v.op; funct = v.fn; mem_ready = v.rdy; z = v.zz;
    #1;
    check(name, act, v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int st, input bit rdy, input bit zz, input string name);
    vec_t v;
    v.op = cur_op; v.fn = cur_fn; v.rdy = rdy; v.zz = zz;
    v.exp = exp_out(st, rdy, zz);
    apply_vec(v, name);
  endtask

  // A memory wait phase: 'stalls' cycles without ready, then completion or timeout.
  task automatic mem_phase(input int st, input int stalls, output bit to);
    int n = (stalls > 14) ? 15 : stalls;
    for (int i = 0; i < n; i++) step(st, 1'b0, rb(), "mem_stall");
    if (stalls >= 15) begin
      to = 1'b1;
      berr_s = 1'b1;
    end else begin
      step(st, 1'b1, rb(), "mem_done");
      to = 1'b0;
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) step(12, rb(), rb(), "halt_hold");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b1; z = 1'b1;
    #1;
    check("reset_assert", act, '0);
    ill_s = 1'b0; berr_s = 1'b0;
    @(posedge clk);
    #1;
    check("reset_hold", act, '0);
    rst_n = 1'b1;
  endtask

  // One whole instruction traced from the rules: fetch, decode, then its own path.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn,
                          input int fs, input int ms, input bit zz);
    bit to;
    cur_op = op; cur_fn = fn;
    mem_phase(0, fs, to);
    if (to) begin halt_hold(3); do_reset(); return; end
    step(1, rb(), rb(), "decode");
    if (is_illegal(op, fn)) begin
      ill_s = 1'b1;
      halt_hold(3);
      do_reset();
      return;
    end
    case (op)
      OP_R:    begin step(6, rb(), rb(), "r_exec"); step(7, rb(), rb(), "r_wb"); end
      OP_LW:   begin
        step(2, rb(), rb(), "lw_addr");
        mem_phase(3, ms, to);
        if (to) begin halt_hold(2); do_reset(); return; end
        step(4, rb(), rb(), "lw_wb");
      end
      OP_SW:   begin
        step(2, rb(), rb(), "sw_addr");
        mem_phase(5, ms, to);
        if (to) begin halt_hold(2); do_reset(); return; end
      end
      OP_BEQ:  step(8, rb(), zz, "branch");
      OP_ADDI: begin step(10, rb(), rb(), "addi_exec"); step(11, rb(), rb(), "addi_wb"); end
      default: step(9, rb(), rb(), "jump");
    endcase
  endtask

  function automatic int pick_stalls();
    if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 3));
    return ($urandom_range(0, 1) != 0) ? 14 : 15;
  endfunction

  vec_t table_v[16];

  initial begin
    localparam ctrl_t F0 = {3'b010, 1'b0, 2'b01, 2'b00, 10'b1010100000, 4'd0};
    localparam ctrl_t D1 = {3'b010, 1'b0, 2'b11, 2'b00, 10'b0000000000, 4'd1};
    localparam ctrl_t W7 = {3'b000, 1'b0, 2'b00, 2'b00, 10'b0000010100, 4'd7};
    table_v[0]  = '{6'b000000, 6'b100000, 1'b1, 1'b0, F0};
    table_v[1]  = '{6'b000000, 6'b100000, 1'b1, 1'b0, D1};
    table_v[2]  = '{6'b000000, 6'b100000, 1'b1, 1'b0, {3'b010, 1'b1, 2'b00, 2'b00, 10'b0, 4'd6}};
    table_v[3]  = '{6'b000000, 6'b100000, 1'b1, 1'b0, W7};
    table_v[4]  = '{6'b000000, 6'b101010, 1'b1, 1'b0, F0};
    table_v[5]  = '{6'b000000, 6'b101010, 1'b1, 1'b0, D1};
    table_v[6]  = '{6'b000000, 6'b101010, 1'b1, 1'b0, {3'b111, 1'b1, 2'b00, 2'b00, 10'b0, 4'd6}};
    table_v[7]  = '{6'b000000, 6'b101010, 1'b1, 1'b0, W7};
    table_v[8]  = '{6'b000000, 6'b100010, 1'b1, 1'b0, F0};
    table_v[9]  = '{6'b000000, 6'b100010, 1'b1, 1'b0, D1};
    table_v[10] = '{6'b000000, 6'b100010, 1'b1, 1'b0, {3'b110, 1'b1, 2'b00, 2'b00, 10'b0, 4'd6}};
    table_v[11] = '{6'b000000, 6'b100010, 1'b1, 1'b0, W7};
    table_v[12] = '{6'b000000, 6'b100111, 1'b1, 1'b0, F0};
    table_v[13] = '{6'b000000, 6'b100111, 1'b1, 1'b0, D1};
    table_v[14] = '{6'b000000, 6'b100111, 1'b1, 1'b0, {3'b011, 1'b1, 2'b00, 2'b00, 10'b0, 4'd6}};
    table_v[15] = '{6'b000000, 6'b100111, 1'b1, 1'b0, W7};

    rst_n = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b1; z = 1'b1;
    ill_s = 1'b0; berr_s = 1'b0; cur_op = '0; cur_fn = 6'b100000;
    @(posedge clk);
    #1;
    check("reset_initial", act, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) apply_vec(table_v[i], "table");

    // Directed corners.
    do_instr(OP_LW, 6'd0, 0, 3, 1'b0);          // three MEM_READ stalls
    do_instr(OP_SW, 6'd0, 2, 14, 1'b0);         // ready on the limit cycle wins
    do_instr(OP_BEQ, 6'd0, 0, 0, 1'b1);
    do_instr(OP_BEQ, 6'd0, 0, 0, 1'b0);
    do_instr(OP_J, 6'd0, 1, 0, 1'b0);
    do_instr(OP_ADDI, 6'd0, 0, 0, 1'b0);
    do_instr(6'b111111, 6'd0, 0, 0, 1'b0);      // illegal opcode -> HALT
    do_instr(OP_R, 6'b000000, 0, 0, 1'b0);      // illegal funct -> HALT
    do_instr(OP_R, 6'b100000, 15, 0, 1'b0);     // FETCH timeout -> HALT, bus_err
    do_instr(OP_LW, 6'd0, 0, 15, 1'b0);         // MEM_READ timeout

    // Reset in the middle of a store aborts it with all strobes low.
    cur_op = OP_SW; cur_fn = 6'd0;
    step(0, 1'b1, 1'b0, "abort_fetch");
    step(1, 1'b0, 1'b0, "abort_decode");
    step(2, 1'b1, 1'b0, "abort_addr");
    step(5, 1'b0, 1'b0, "abort_write");
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      int sel = int'($urandom_range(0, 19));
      fn = 6'd0;
      if (sel < 17) begin
        case (sel % 6)
          0: op = OP_R;
          1: op = OP_LW;
          2: op = OP_SW;
          3: op = OP_BEQ;
          4: op = OP_ADDI;
          default: op = OP_J;
        endcase
        if (op == OP_R) fn = alu_fn_pick();
        else fn = 6'($urandom_range(0, 63));
      end else if (sel < 19) begin
        op = 6'($urandom_range(0, 63));
        if (!is_illegal(op, 6'd0)) op = 6'b111111;
      end else begin
        op = OP_R;
        fn = 6'($urandom_range(0, 63));
        if (legal_funct(fn)) fn = 6'd0;
      end
      do_instr(op, fn, pick_stalls(), pick_stalls(), rb());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic logic [5:0] alu_fn_pick();
    case ($urandom_range(0, 5))
      0: return 6'b100100;
      1: return 6'b100101;
      2: return 6'b100000;
      3: return 6'b100111;
      4: return 6'b100010;
      default: return 6'b101010;
    endcase
  endfunction

endmodule
